seq_divider_32by16: RTL
=======================

// Module: seq_divider_32by16
// PURPOSE
//   Sequential radix-2 restoring divider: 2*W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
//   Inverse companion of the 16x16 Vedic multiplier; same start/done handshake, so a product feeds straight back in.
//   Used by the matrix datapath for normalisation/scaling. Serial by design (one quotient bit per clock) to save area.
// PARAMETERS
//   W    16   divisor/quotient/remainder width; dividend is 2*W bits (must be >= 2)
// PORTS
//   clk          in   1     rising-edge clock
//   reset        in   1     asynchronous, active-LOW reset (0 = reset asserted)
//   dividend     in   2W    numerator, sampled only on accepted start
//   divisor      in   W     denominator, sampled only on accepted start
//   start        in   1     request; accepted only in IDLE
//   busy         out  1     1 whenever state != IDLE
//   quotient     out  W     result; held from done until next accepted start
//   remainder    out  W     result; held likewise
//   overflow     out  1     quotient does not fit in W bits (saturated)
//   div_by_zero  out  1     divisor was 0
//   done         out  1     single-cycle pulse, outputs valid from this cycle
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; busy, done, overflow, div_by_zero = 0; quotient, remainder = 0.
//   FSM: IDLE -> CALC -> [FIX] -> DONE -> IDLE.
//     IDLE: start=1 at edge E0 latches operands, clears flags. divisor==0 -> DONE (div_by_zero=1,
//       quotient=all-ones, remainder=dividend[W-1:0]). dividend[2W-1:W] >= divisor -> DONE (overflow=1,
//       quotient=all-ones, remainder=0). Else -> CALC with iteration counter = W-1.
//     CALC: per edge: partial remainder P (W+1 bits) = {P, next dividend bit}; if P >= divisor then
//       P -= divisor, q bit=1 else q bit=0; counter decrements; at counter==0 -> DONE (or FIX).
//       Initial P = dividend[2W-1:W]; dividend low half shifts in MSB-first.
//     DONE: done=1 for exactly this cycle, outputs already registered; unconditional -> IDLE.
//   Latency: normal = done high W+1 cycles after E0 (W+2 with DIV_SIGNED_EN); exceptions = done high 1 cycle after E0.
//   Throughput: next start accepted earliest in cycle after DONE; start while busy (incl. DONE) ignored, no queueing.
//   start held high continuously: re-accepted each time FSM returns to IDLE.
//   Comparison P >= divisor uses W+1 bits, no truncation; remainder always < divisor on normal completion.
//   Operand inputs may change freely after E0; internal copies used.
//   Reset mid-CALC: aborts immediately, no done pulse, outputs return to reset values.
// CONFIGURATION
//   DIV_SIGNED_EN defined: operands two's complement. E0 takes magnitudes; CALC is unsigned; FIX state
//     (one extra cycle) negates quotient if signs differ, remainder takes dividend's sign (truncating division).
//     overflow also set if magnitude quotient > 2^(W-1)-1 (positive result) or > 2^(W-1) (negative result);
//     saturates to 0x7FFF / 0x8000 (W=16) respectively, remainder=0. div_by_zero behaviour unchanged.
//   DIV_SIGNED_EN undefined: unsigned only; no FIX state, no magnitude/negation logic compiled in.
// TESTING (W=16)
//   1000 / 7 -> quotient=142, remainder=6, overflow=0, done pulse exactly 17 cycles after start edge.
//   0xFFFE_FFFF / 0xFFFF -> quotient=0xFFFF, remainder=0xFFFE, overflow=0 (max non-overflow case).
//   0x0001_0000 / 1 -> overflow=1, quotient=0xFFFF, remainder=0, done 1 cycle after start; 5 / 0 -> div_by_zero=1, q=0xFFFF, r=5.
//   start re-pulsed at cycles 3 and 10 of a 1000/7 op -> ignored, single done, result unchanged; reset low at cycle 8 -> busy=0, no done.
//   DIV_SIGNED_EN: 0xFFFF_FF9C (-100) / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2), done at 18 cycles.
//   DIV_SIGNED_EN: 0x0000_8000 / 1 -> overflow=1, quotient=0x7FFF; 0xFFFF_8000 / 1 -> overflow=0, quotient=0x8000.

Source files
------------

// File: rtl/seq_divider_32by16.sv
// Sequential radix-2 restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Optional two's-complement mode is compiled in when DIV_SIGNED_EN is defined.
module seq_divider_32by16 #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    input  logic             start,
    output logic             busy,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled on a rising edge only while IDLE; done pulses for the
    // single DONE cycle, after which quotient/remainder/flags hold until the next accepted start.

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  ALL_ONES = '1;
`ifdef DIV_SIGNED_EN
    localparam logic [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};
`endif

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t state, state_next;

    logic [W-1:0]   p_q;
    logic [W-1:0]   lo_q;
    logic [W-1:0]   dvsr_q;
    logic [CW-1:0]  cnt_q;

    logic [2*W-1:0] dd_mag;
    logic [W-1:0]   dv_mag;
    logic           dz;
    logic           ovf0;
    logic [W:0]     trial;
    logic           ge;
    logic [W-1:0]   p_step;
    logic [W-1:0]   lo_step;
    logic [W-1:0]   ovf_sat;

`ifdef DIV_SIGNED_EN
    logic           neg_q_r;
    logic           neg_r_r;
    logic           neg_q_in;
    logic           fix_ovf;

    assign dd_mag   = dividend[2*W-1] ? (~dividend + 1'b1) : dividend;
    assign dv_mag   = divisor[W-1]    ? (~divisor + 1'b1)  : divisor;
    assign neg_q_in = dividend[2*W-1] ^ divisor[W-1];
    assign ovf_sat  = neg_q_in ? SMIN : SMAX;
    // The magnitude quotient may reach 2^(W-1) only when the result is negative.
    assign fix_ovf  = neg_q_r ? (lo_q > SMIN) : (lo_q > SMAX);
`else
    assign dd_mag  = dividend;
    assign dv_mag  = divisor;
    assign ovf_sat = ALL_ONES;
`endif

    assign dz   = (divisor == '0);
    assign ovf0 = (dd_mag[2*W-1:W] >= dv_mag);

    // P < divisor between steps, so the shifted trial always fits in W+1 bits and
    // the W-bit subtraction result is exact whenever ge is set.
    assign trial   = {p_q, lo_q[W-1]};
    assign ge      = (trial >= {1'b0, dvsr_q});
    assign p_step  = ge ? (trial[W-1:0] - dvsr_q) : trial[W-1:0];
    assign lo_step = {lo_q[W-2:0], ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (dz || ovf0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
                    state_next = S_FIX;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
                state_next = S_DONE;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q         <= '0;
            lo_q        <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        p_q         <= dd_mag[2*W-1:W];
                        lo_q        <= dd_mag[W-1:0];
                        dvsr_q      <= dv_mag;
                        cnt_q       <= CNT_LAST;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q_r     <= neg_q_in;
                        neg_r_r     <= dividend[2*W-1];
`endif
                        if (dz) begin
                            div_by_zero <= 1'b1;
                            quotient    <= ALL_ONES;
                            remainder   <= dividend[W-1:0];
                        end else if (ovf0) begin
                            overflow    <= 1'b1;
                            quotient    <= ovf_sat;
                            remainder   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    p_q   <= p_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q - 1'b1;
`ifndef DIV_SIGNED_EN
                    if (cnt_q == '0) begin
                        quotient  <= lo_step;
                        remainder <= p_step;
                    end
`endif
                end
`ifdef DIV_SIGNED_EN
                S_FIX: begin
                    if (fix_ovf) begin
                        overflow  <= 1'b1;
                        quotient  <= neg_q_r ? SMIN : SMAX;
                        remainder <= '0;
                    end else begin
                        quotient  <= neg_q_r ? (~lo_q + 1'b1) : lo_q;
                        remainder <= neg_r_r ? (~p_q + 1'b1) : p_q;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
